// File: rtl/wb_src_sequencer_if.sv
// Write-back request and register-file port bundle between the main control
// unit (master) and the write-back sequencer (slave).
interface wb_src_sequencer_if;
    logic       req_valid;
    logic [2:0] req_src;
    logic [4:0] req_rd;
    logic       mem_ready;
    logic       md_busy;
    logic       req_ready;
    logic [2:0] DataSrcControl;
    logic       RegWrite;
    logic [4:0] WriteReg;
    logic       wb_done;
    logic       wb_err;
    logic [7:0] write_count;

    modport master (
        output req_valid, req_src, req_rd, mem_ready, md_busy,
        input  req_ready, DataSrcControl, RegWrite, WriteReg,
               wb_done, wb_err, write_count
    );

    modport slave (
        input  req_valid, req_src, req_rd, mem_ready, md_busy,
        output req_ready, DataSrcControl, RegWrite, WriteReg,
               wb_done, wb_err, write_count
    );
endinterface

// File: rtl/wb_src_sequencer.sv
// Write-back sequencer: waits for the selected data source to become valid,
// then issues a single-cycle RegWrite, or aborts on an illegal code or timeout.
module wb_src_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic               clk,
    input logic               reset_n,
    wb_src_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE,
        S_ERR
    } state_t;

    state_t     state_q;
    logic [7:0] count_q;
    logic [7:0] count_d;
    logic [2:0] src_q;
    logic [4:0] rd_q;
    logic       ready_q;
    logic       regWrite_q;
    logic       done_q;
    logic       err_q;
    logic [7:0] writes_q;
    logic [7:0] writes_d;
    logic       srcReady;

    // LS output needs the memory handshake, HI/LO need an idle mult/div unit.
    always_comb begin
        srcReady = 1'b1;
        case (src_q)
            3'b000:         srcReady = bus.mem_ready;
            3'b001, 3'b010: srcReady = ~bus.md_busy;
            default:        srcReady = 1'b1;
        endcase
    end

    assign count_d  = count_q + 8'd1;
    assign writes_d = writes_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            count_q    <= 8'd0;
            src_q      <= 3'b000;
            rd_q       <= 5'd0;
            ready_q    <= 1'b1;
            regWrite_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            writes_q   <= 8'd0;
        end else begin
            regWrite_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        src_q   <= bus.req_src;
                        rd_q    <= bus.req_rd;
                        count_q <= 8'd0;
                        ready_q <= 1'b0;
                        if (bus.req_src == 3'b111) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (srcReady) begin
                        state_q    <= S_WRITE;
                        done_q     <= 1'b1;
                        // Writes to $zero complete but never reach the register file.
                        regWrite_q <= (rd_q != 5'd0);
                    end else if (count_q == 8'(TIMEOUT - 1)) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        count_q <= count_d;
                    end
                end
                S_WRITE: begin
                    if (regWrite_q) begin
                        writes_q <= writes_d;
                    end
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready      = ready_q;
    assign bus.DataSrcControl = src_q;
    assign bus.WriteReg       = rd_q;
    assign bus.RegWrite       = regWrite_q;
    assign bus.wb_done        = done_q;
    assign bus.wb_err         = err_q;
    assign bus.write_count    = writes_q;

endmodule

// File: tb/tb_wb_src_sequencer.sv
// Scoreboard bench for wb_src_sequencer: requests push expected completions,
// a negedge monitor pops and compares them when wb_done/wb_err appear.
module tb_wb_src_sequencer;

    logic clk;
    logic reset_n;
    int   cycle;
    int   checks;
    int   errors;

    typedef struct {
        int         cyc;
        logic       err;
        logic       rw;
        logic [2:0] src;
        logic [4:0] rd;
    } exp_t;

    exp_t sb[$];

    wb_src_sequencer_if bus ();

    wb_src_sequencer #(.TIMEOUT(15)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Waits for req_ready, presents one request, and queues its expected completion.
    task automatic applyStimulus(input logic [2:0] src, input logic [4:0] rd, input int lat,
                                 input logic expRw, input logic expErr, input bit expectResp);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) checkOutput("readyTimeout", 0, 1);
        bus.req_valid = 1'b1;
        bus.req_src   = src;
        bus.req_rd    = rd;
        if (expectResp) begin
            e.cyc = cycle + 1 + lat;
            e.err = expErr;
            e.rw  = expRw;
            e.src = src;
            e.rd  = rd;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_src   = $urandom_range(7, 0);
        bus.req_rd    = $urandom_range(31, 0);
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) checkOutput("idleTimeout", 0, 1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, int'(bus.req_ready), 1);
        checkOutput({tag, "_src"}, int'(bus.DataSrcControl), 0);
        checkOutput({tag, "_rd"}, int'(bus.WriteReg), 0);
        checkOutput({tag, "_rw"}, int'(bus.RegWrite), 0);
        checkOutput({tag, "_done"}, int'(bus.wb_done), 0);
        checkOutput({tag, "_err"}, int'(bus.wb_err), 0);
        checkOutput({tag, "_count"}, int'(bus.write_count), 0);
    endtask

    // Monitor: every completion pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.RegWrite && !bus.wb_done) checkOutput("strayRegWrite", 1, 0);
            if (bus.wb_done || bus.wb_err) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpectedPulse", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("respCycle", cycle, e.cyc);
                    checkOutput("respErr", int'(bus.wb_err), int'(e.err));
                    checkOutput("respDone", int'(bus.wb_done), int'(!e.err));
                    checkOutput("respRegWrite", int'(bus.RegWrite), int'(e.rw));
                    checkOutput("respSrc", int'(bus.DataSrcControl), int'(e.src));
                    checkOutput("respRd", int'(bus.WriteReg), int'(e.rd));
                end
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_src   = 3'b000;
        bus.req_rd    = 5'd0;
        bus.mem_ready = 1'b0;
        bus.md_busy   = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset_n = 1'b1;

        // ALUOut to r8: two cycles to completion.
        applyStimulus(3'b110, 5'd8, 1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("readyFalls", int'(bus.req_ready), 0);
        waitIdle();
        checkOutput("countAfterAlu", int'(bus.write_count), 1);

        // LS_out to r5 with mem_ready low for four WAIT samples.
        applyStimulus(3'b000, 5'd5, 5, 1'b1, 1'b0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            checkOutput("lsSrcHold", int'(bus.DataSrcControl), 0);
            checkOutput("lsNoEarlyWrite", int'(bus.RegWrite), 0);
        end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        waitIdle();
        bus.mem_ready = 1'b0;
        checkOutput("countAfterLs", int'(bus.write_count), 2);

        // HI with mult/div busy: timeout abort.
        bus.md_busy = 1'b1;
        applyStimulus(3'b001, 5'd3, 15, 1'b0, 1'b1, 1'b1);
        waitIdle();
        repeat (3) @(negedge clk);
        bus.md_busy = 1'b0;
        checkOutput("countAfterTimeout", int'(bus.write_count), 2);

        // Illegal code, then constant to $zero.
        applyStimulus(3'b111, 5'd9, 0, 1'b0, 1'b1, 1'b1);
        waitIdle();
        applyStimulus(3'b100, 5'd0, 1, 1'b0, 1'b0, 1'b1);
        waitIdle();
        checkOutput("countAfterZero", int'(bus.write_count), 2);

        // Reset during WAIT of a LO request drops it silently.
        bus.md_busy = 1'b1;
        applyStimulus(3'b010, 5'd4, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checkResetValues("midReset");
        reset_n     = 1'b1;
        bus.md_busy = 1'b0;
        applyStimulus(3'b011, 5'd31, 1, 1'b1, 1'b0, 1'b1);
        waitIdle();
        checkOutput("countAfterShift", int'(bus.write_count), 1);

        // 256 writes to r1 from a clean count: wraps back to zero.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checkOutput("countCleared", int'(bus.write_count), 0);
        for (int i = 0; i < 255; i++) begin
            applyStimulus(3'b110, 5'd1, 1, 1'b1, 1'b0, 1'b1);
        end
        waitIdle();
        checkOutput("count255", int'(bus.write_count), 255);
        applyStimulus(3'b101, 5'd1, 1, 1'b1, 1'b0, 1'b1);
        waitIdle();
        checkOutput("countWrap", int'(bus.write_count), 0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardEmpty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_src_sequencer.md
# wb_src_sequencer

Write-back sequencer for the register-file data path of the multicycle MIPS core. It accepts one write-back request at a time from the main control unit, naming a data source and a destination register. It waits until that source is valid: load/store output after a memory handshake, HI/LO after the mult/div unit goes idle, all other sources immediately. It then drives the `DataSrcControl` select of the write-back mux and issues a single-cycle `RegWrite`. Stalled requests are aborted by a timeout, and illegal source codes are flagged.

## Interface
- `TIMEOUT`, default 15: maximum number of not-ready cycles tolerated in WAIT before abort (1..255).
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  control unit presents a write-back request.
- `req_src`  in  3  source code: 000 LS_out, 001 HI, 010 LO, 011 ShiftReg, 100 constant 227, 101 SE1_32, 110 ALUOut, 111 illegal.
- `req_rd`  in  5  destination register number.
- `mem_ready`  in  1  LS_out valid this cycle.
- `md_busy`  in  1  mult/div unit still updating HI/LO.
- `req_ready`  out  1  sequencer can accept a request.
- `DataSrcControl`  out  3  select for the write-back mux.
- `RegWrite`  out  1  register-file write enable.
- `WriteReg`  out  5  register-file write address.
- `wb_done`  out  1  one-cycle pulse: request completed normally.
- `wb_err`  out  1  one-cycle pulse: request aborted (illegal code or timeout).
- `write_count`  out  8  number of completed register writes, wraps 255->0.

## Operation
- Reset values, applied when `reset_n` is low at an edge:
  - state = IDLE
  - `DataSrcControl` = 000, `WriteReg` = 0, `write_count` = 0
  - `RegWrite`, `wb_done`, `wb_err`, timeout counter = 0
  - `req_ready` = 1
- States:
  - IDLE:
    - `req_ready` = 1.
    - On `req_valid`, latch `req_src` into `DataSrcControl` and `req_rd` into `WriteReg`.
    - Next state is ERR if src = 111, otherwise WAIT with counter = 0.
  - WAIT:
    - Readiness condition: src 000 requires `mem_ready` = 1; src 001/010 require `md_busy` = 0; src 011/100/101/110 are always ready.
    - Condition true: next state WRITE.
    - Condition false and counter = TIMEOUT-1: next state ERR.
    - Otherwise, increment the counter.
  - WRITE:
    - `RegWrite` = 1, unless `WriteReg` = 0, in which case the write to $zero is suppressed.
    - `wb_done` = 1 in either case.
    - `write_count` increments only when `RegWrite` was asserted.
    - Next state IDLE.
  - ERR: `wb_err` = 1, `RegWrite` = 0. Next state IDLE.
- `req_ready` = 0 in WAIT, WRITE and ERR. `req_valid` is ignored outside IDLE.
- `DataSrcControl` and `WriteReg` hold their latched values from accept until the next accept. They also remain stable in IDLE, so the mux output never glitches during a write.
- `RegWrite`, `wb_done` and `wb_err` are decoded from the registered state, so they carry no combinational path from inputs.

## Timing
- Accept happens at edge E0, when state=IDLE and `req_valid`=1. WAIT is occupied during cycle E0..E1.
- For immediately-ready sources, WRITE occupies cycle E1..E2. `RegWrite` is high for exactly one cycle, and `req_ready` returns high at E2. Throughput is one request per 3 cycles.
- For LS/HI/LO sources, WRITE occupies the cycle after the first WAIT cycle in which the condition is sampled true.
- Timeout: TIMEOUT consecutive false WAIT cycles lead to one ERR cycle, then IDLE. With TIMEOUT=15, `wb_err` is high during the 16th cycle after accept.
- Illegal code: ERR occupies cycle E0..E1, and no WAIT state is entered.
- Synchronous reset takes priority over all transitions in any state. If reset is asserted during WAIT/WRITE:
  - no `RegWrite` occurs on the cycle after the reset edge;
  - the pending request is dropped;
  - no `wb_done`/`wb_err` is issued for it.
- `write_count` wraps modulo 256 without flag.

## Test plan
- Request src=110, rd=8 in IDLE, then:
  - `req_ready` falls next cycle.
  - `RegWrite`=1, `WriteReg`=8, `DataSrcControl`=110 and `wb_done`=1 in the 2nd cycle after accept.
  - `write_count` goes 0->1.
- Request src=000, rd=5 with `mem_ready` low for 4 cycles, then high:
  - `RegWrite` asserts exactly one cycle after the first `mem_ready`=1 sample.
  - `DataSrcControl`=000 throughout.
- Request src=001 with `md_busy` high for 20 cycles (TIMEOUT=15):
  - `wb_err` pulses in the 16th cycle after accept.
  - `RegWrite` never asserts; `write_count` unchanged.
- Request src=111, then request src=100, rd=0:
  - The first request gives `wb_err` in the cycle after accept and no WAIT.
  - The second gives `wb_done`=1 with `RegWrite`=0 ($zero suppression) and `write_count` unchanged.
- Assert `reset_n`=0 during WAIT of a src=010 request:
  - Next cycle all outputs are at reset values and `req_ready`=1.
  - A subsequent src=011, rd=31 request completes normally.
- Complete 256 writes to rd=1: `write_count` wraps to 0.
